// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// apb_master : command/response to APB bridge, one outstanding transfer,
//              ACCESS-phase timeout abort.               Revision: 1.0
// ============================================================================
module apb_master #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 16
) (
  input  logic            pclk,
  input  logic            presetn,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic [AW-1:0]   i_cmd_addr,
  input  logic            i_cmd_write,
  input  logic [DW-1:0]   i_cmd_wdata,
  input  logic [DW/8-1:0] i_cmd_strb,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [DW-1:0]   o_rsp_rdata,
  output logic            o_rsp_err,
  output logic            o_rsp_tmo,
  output logic [AW-1:0]   o_paddr,
  output logic            o_pwrite,
  output logic            o_psel,
  output logic            o_penable,
  output logic [DW-1:0]   o_pwdata,
  output logic [DW/8-1:0] o_pstrb,
  input  logic [DW-1:0]   i_prdata,
  input  logic            i_pslverr,
  input  logic            i_pready
);

  localparam int SW = DW / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] c_tmo_last = TMO_LAST[CW-1:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic            pwrite_q, pwrite_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic [SW-1:0]   pstrb_q, pstrb_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            tmo_q, tmo_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          state_d  = SETUP;
          paddr_d  = i_cmd_addr;
          pwrite_d = i_cmd_write;
          pwdata_d = i_cmd_wdata;
          pstrb_d  = i_cmd_write ? i_cmd_strb : '0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (i_pready) begin
          state_d = RESP;
          rdata_d = pwrite_q ? '0 : i_prdata;
          err_d   = i_pslverr;
          tmo_d   = 1'b0;
        end else if ((TIMEOUT > 0) && (cnt_q == c_tmo_last)) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
        end else if (TIMEOUT > 0) begin
          // Abort fires at TIMEOUT-1, so the counter can never wrap.
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake/phase outputs decode straight from the registered state.
  assign o_cmd_ready = (state_q == IDLE);
  assign o_psel      = (state_q == SETUP) || (state_q == ACCESS);
  assign o_penable   = (state_q == ACCESS);
  assign o_rsp_valid = (state_q == RESP);
  assign o_paddr     = paddr_q;
  assign o_pwrite    = pwrite_q;
  assign o_pwdata    = pwdata_q;
  assign o_pstrb     = pstrb_q;
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;
  assign o_rsp_tmo   = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
// tb_apb_master : directed self-checking bench for apb_master.
//                                                        Revision: 1.0
// ============================================================================
module tb_apb_master;

  logic        pclk;
  logic        presetn;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [4:0]  i_cmd_addr;
  logic        i_cmd_write;
  logic [31:0] i_cmd_wdata;
  logic [3:0]  i_cmd_strb;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_rsp_tmo;
  logic [4:0]  o_paddr;
  logic        o_pwrite;
  logic        o_psel;
  logic        o_penable;
  logic [31:0] o_pwdata;
  logic [3:0]  o_pstrb;
  logic [31:0] i_prdata;
  logic        i_pslverr;
  logic        i_pready;

  int n_vec = 0;
  int n_err = 0;
  int en_cyc;

  apb_master #(.DW(32), .AW(5), .TIMEOUT(16)) u_dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_addr  (i_cmd_addr),
    .i_cmd_write (i_cmd_write),
    .i_cmd_wdata (i_cmd_wdata),
    .i_cmd_strb  (i_cmd_strb),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_err   (o_rsp_err),
    .o_rsp_tmo   (o_rsp_tmo),
    .o_paddr     (o_paddr),
    .o_pwrite    (o_pwrite),
    .o_psel      (o_psel),
    .o_penable   (o_penable),
    .o_pwdata    (o_pwdata),
    .o_pstrb     (o_pstrb),
    .i_prdata    (i_prdata),
    .i_pslverr   (i_pslverr),
    .i_pready    (i_pready)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    @(negedge pclk);
  endtask

  // Issues one command, then plays an APB slave that raises pready after
  // 'waits' ACCESS cycles. Returns the number of cycles penable was high.
  task automatic xfer(input logic [4:0] a, input logic w, input logic [31:0] wd,
                      input logic [3:0] st, input int waits, input logic [31:0] rd,
                      input logic err, output int en);
    logic [3:0] exp_strb;
    exp_strb = w ? st : 4'h0;
    i_pready = 1'b0;
    check("cmd_ready_idle", o_cmd_ready, 1'b1);
    i_cmd_valid = 1'b1;
    i_cmd_addr  = a;
    i_cmd_write = w;
    i_cmd_wdata = wd;
    i_cmd_strb  = st;
    tick();
    i_cmd_valid = 1'b0;
    check("setup_psel", o_psel, 1'b1);
    check("setup_penable", o_penable, 1'b0);
    check("setup_cmd_ready", o_cmd_ready, 1'b0);
    check("setup_paddr", o_paddr, a);
    check("setup_pwrite", o_pwrite, w);
    check("setup_pwdata", o_pwdata, wd);
    check("setup_pstrb", o_pstrb, exp_strb);
    en = 0;
    for (int k = 0; k < 64; k++) begin
      tick();
      if (!o_penable) break;
      en++;
      check("access_psel", o_psel, 1'b1);
      check("hold_paddr", o_paddr, a);
      check("hold_pwdata", o_pwdata, wd);
      check("hold_pstrb", o_pstrb, exp_strb);
      if (en > waits) begin
        i_pready  = 1'b1;
        i_prdata  = rd;
        i_pslverr = err;
      end
    end
    check("access_bounded", {63'd0, o_penable}, 64'd0);
    i_pready  = 1'b0;
    i_pslverr = 1'b0;
    i_prdata  = 32'hFFFF_FFFF;
    check("resp_psel", o_psel, 1'b0);
    check("resp_valid", o_rsp_valid, 1'b1);
    check("resp_cmd_ready", o_cmd_ready, 1'b0);
  endtask

  task automatic consume();
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    check("after_rsp_valid", o_rsp_valid, 1'b0);
    check("after_rsp_cmd_ready", o_cmd_ready, 1'b1);
  endtask

  initial begin
    presetn     = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd_addr  = 5'd0;
    i_cmd_write = 1'b0;
    i_cmd_wdata = 32'd0;
    i_cmd_strb  = 4'd0;
    i_rsp_ready = 1'b0;
    i_prdata    = 32'hFFFF_FFFF;
    i_pslverr   = 1'b0;
    i_pready    = 1'b0;

    // Reset state
    #12;
    check("rst_psel", o_psel, 1'b0);
    check("rst_penable", o_penable, 1'b0);
    check("rst_rsp_valid", o_rsp_valid, 1'b0);
    check("rst_pwrite", o_pwrite, 1'b0);
    check("rst_paddr", o_paddr, 5'd0);
    check("rst_pwdata", o_pwdata, 32'd0);
    check("rst_pstrb", o_pstrb, 4'd0);
    check("rst_rdata", o_rsp_rdata, 32'd0);
    check("rst_err", {o_rsp_err, o_rsp_tmo}, 2'b00);
    @(negedge pclk);
    presetn = 1'b1;
    #1;
    check("rel_cmd_ready", o_cmd_ready, 1'b1);
    @(negedge pclk);

    // Zero-wait write
    xfer(5'h00, 1'b1, 32'hA5A5_0001, 4'hF, 0, 32'h0, 1'b0, en_cyc);
    check("wr_penable_cycles", en_cyc, 1);
    check("wr_err", o_rsp_err, 1'b0);
    check("wr_tmo", o_rsp_tmo, 1'b0);
    check("wr_rdata", o_rsp_rdata, 32'h0);
    consume();

    // Read with one wait state; strobes must be forced to zero
    xfer(5'h0C, 1'b0, 32'h0, 4'hF, 1, 32'hDEAD_BEEF, 1'b0, en_cyc);
    check("rd_penable_cycles", en_cyc, 2);
    check("rd_rdata", o_rsp_rdata, 32'hDEAD_BEEF);
    check("rd_err", o_rsp_err, 1'b0);
    check("rd_tmo", o_rsp_tmo, 1'b0);
    consume();

    // Write with slave error; prdata pins carry junk that must not leak
    xfer(5'h10, 1'b1, 32'h1234_5678, 4'h3, 0, 32'hCAFE_F00D, 1'b1, en_cyc);
    check("slverr_err", o_rsp_err, 1'b1);
    check("slverr_tmo", o_rsp_tmo, 1'b0);
    check("slverr_rdata", o_rsp_rdata, 32'h0);
    consume();

    // Timeout: slave never ready
    xfer(5'h04, 1'b0, 32'h0, 4'h0, 1000, 32'h0, 1'b0, en_cyc);
    check("tmo_penable_cycles", en_cyc, 16);
    check("tmo_err", o_rsp_err, 1'b1);
    check("tmo_tmo", o_rsp_tmo, 1'b1);
    check("tmo_rdata", o_rsp_rdata, 32'h0);
    consume();

    // Response back-pressure with a pending command
    xfer(5'h08, 1'b0, 32'h0, 4'h0, 0, 32'h1357_9BDF, 1'b0, en_cyc);
    i_cmd_valid = 1'b1;
    i_cmd_addr  = 5'h14;
    i_cmd_write = 1'b1;
    i_cmd_wdata = 32'h0BAD_F00D;
    i_cmd_strb  = 4'h5;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_rsp_valid", o_rsp_valid, 1'b1);
      check("bp_rdata", o_rsp_rdata, 32'h1357_9BDF);
      check("bp_err", {o_rsp_err, o_rsp_tmo}, 2'b00);
      check("bp_cmd_ready", o_cmd_ready, 1'b0);
      check("bp_psel", o_psel, 1'b0);
    end
    i_rsp_ready = 1'b1;
    tick();
    i_rsp_ready = 1'b0;
    check("bp_release_valid", o_rsp_valid, 1'b0);
    check("bp_release_cmd_ready", o_cmd_ready, 1'b1);
    check("bp_release_psel", o_psel, 1'b0);
    tick();
    i_cmd_valid = 1'b0;
    check("bp_next_psel", o_psel, 1'b1);
    check("bp_next_paddr", o_paddr, 5'h14);
    check("bp_next_pstrb", o_pstrb, 4'h5);
    tick();
    check("bp_next_penable", o_penable, 1'b1);
    i_pready = 1'b1;
    tick();
    i_pready = 1'b0;
    check("bp_next_rsp_valid", o_rsp_valid, 1'b1);
    check("bp_next_rdata", o_rsp_rdata, 32'h0);
    consume();

    // Reset asserted mid-ACCESS
    i_cmd_valid = 1'b1;
    i_cmd_addr  = 5'h1C;
    i_cmd_write = 1'b1;
    i_cmd_wdata = 32'h7777_8888;
    i_cmd_strb  = 4'hF;
    tick();
    i_cmd_valid = 1'b0;
    tick();
    check("mid_penable", o_penable, 1'b1);
    #2;
    presetn = 1'b0;
    #1;
    check("arst_psel", o_psel, 1'b0);
    check("arst_penable", o_penable, 1'b0);
    check("arst_rsp_valid", o_rsp_valid, 1'b0);
    check("arst_paddr", o_paddr, 5'd0);
    i_pready = 1'b1;
    @(negedge pclk);
    i_pready = 1'b0;
    presetn  = 1'b1;
    #1;
    check("arst_rel_cmd_ready", o_cmd_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("arst_no_rsp", o_rsp_valid, 1'b0);
      check("arst_idle_psel", o_psel, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
